// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_seq_pkg
//  Description : Shared definitions for the I2C register-initialisation
//                sequencer. This package holds the state encoding and the
//                field positions of a configuration-table entry.
//                IDLE is encoded as all zeros, so the reset value of the
//                state register is IDLE. Every other state has one bit of
//                its own, which gives 8 one-hot bits for the 8 active states.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

    // Table entry layout: {addr[15:0], data[7:0]}
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam logic [7:0] ST_IDLE_ENC    = 8'b0000_0000;
    localparam logic [7:0] ST_PWR_DLY_ENC = 8'b0000_0001;
    localparam logic [7:0] ST_FETCH_ENC   = 8'b0000_0010;
    localparam logic [7:0] ST_LATCH_ENC   = 8'b0000_0100;
    localparam logic [7:0] ST_ISSUE_ENC   = 8'b0000_1000;
    localparam logic [7:0] ST_WAIT_WR_ENC = 8'b0001_0000;
    localparam logic [7:0] ST_VERIFY_ENC  = 8'b0010_0000;
    localparam logic [7:0] ST_NEXT_ENC    = 8'b0100_0000;
    localparam logic [7:0] ST_FIN_ENC     = 8'b1000_0000;

    typedef enum logic [7:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_PWR_DLY = ST_PWR_DLY_ENC,
        ST_FETCH   = ST_FETCH_ENC,
        ST_LATCH   = ST_LATCH_ENC,
        ST_ISSUE   = ST_ISSUE_ENC,
        ST_WAIT_WR = ST_WAIT_WR_ENC,
        ST_VERIFY  = ST_VERIFY_ENC,
        ST_NEXT    = ST_NEXT_ENC,
        ST_FIN     = ST_FIN_ENC
    } seq_state_e;

    function automatic logic [15:0] entry_addr(input logic [23:0] entry);
        return entry[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [7:0] entry_data(input logic [23:0] entry);
        return entry[DATA_MSB:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_delay_cnt
//  Description : Loadable down-counter with a zero flag. A load has priority
//                over a decrement. When the count is zero, the counter holds
//                at zero.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - load i_load_val into the counter
//                i_load_val    - value to load
//                i_dec         - decrement by one (saturates at zero)
//                o_zero        - count is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_delay_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_init_seq
//  Description : Register-initialisation sequencer. It walks a configuration
//                ROM of {addr[15:0], data[7:0]} entries and issues one
//                register write per entry to the I2C register-access
//                controller. A NACK causes a retry, up to MAX_RETRY times.
//                If the last retry also fails, the sequence aborts.
//  Option      : I2C_VERIFY_EN - when defined, each successful write is
//                followed by a read-back of the same register. A failed read
//                or a data mismatch counts as a NACK.
//  Ports       : Clk, Rst      - clock, synchronous active-high reset
//                start         - one-cycle start pulse (ignored while busy)
//                busy/done/err - status; err and err_index are sticky
//                lut_index     - ROM address; lut_data returns 1 cycle later
//                wrreg_req, rdreg_req, addr, wrdata, addr_mode, device_id,
//                dly_cnt_max   - controller request side
//                RW_Done, ack, rddata - controller completion side
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_init_seq
    import i2c_seq_pkg::*;
#(
    parameter int          LUT_SIZE    = 256,
    parameter logic [7:0]  DEVICE_ID   = 8'h78,
    parameter logic        ADDR_MODE   = 1'b1,
    parameter logic [31:0] PWR_DLY_CYC = 32'd1_000_000,
    parameter int          MAX_RETRY   = 3,
    parameter logic [31:0] GAP_CYC     = 32'd500
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  err_index,
    output logic [9:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        wrreg_req,
    output logic        rdreg_req,
    output logic [15:0] addr,
    output logic        addr_mode,
    output logic [7:0]  wrdata,
    output logic [7:0]  device_id,
    output logic [31:0] dly_cnt_max,
    input  logic        RW_Done,
    input  logic        ack,
    input  logic [7:0]  rddata
);

    localparam int             RETRY_W  = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [9:0]     LAST_IDX = 10'(LUT_SIZE - 1);
    // The counter is loaded with N-1, so PWR_DLY lasts N cycles. It lasts a
    // minimum of one cycle, also when PWR_DLY_CYC is 0.
    localparam logic [31:0]    PWR_LOAD = (PWR_DLY_CYC == 32'd0) ? 32'd0
                                                                 : (PWR_DLY_CYC - 32'd1);

    seq_state_e         state_q, state_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [9:0]         err_index_q, err_index_d;
    logic [9:0]         lut_index_q, lut_index_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wrdata_q, wrdata_d;
`ifdef I2C_VERIFY_EN
    // The read request goes out in the first VERIFY cycle only.
    logic               rd_sent_q, rd_sent_d;
`endif

    logic w_dly_load;
    logic w_dly_dec;
    logic w_dly_zero;
    logic w_attempt_fail;

    seq_delay_cnt #(
        .WIDTH (32)
    ) u_pwr_dly (
        .clk        (Clk),
        .rst        (Rst),
        .i_load     (w_dly_load),
        .i_load_val (PWR_LOAD),
        .i_dec      (w_dly_dec),
        .o_zero     (w_dly_zero)
    );

    always_comb begin
        state_d        = state_q;
        busy_d         = busy_q;
        err_d          = err_q;
        err_index_d    = err_index_q;
        lut_index_d    = lut_index_q;
        retry_d        = retry_q;
        addr_d         = addr_q;
        wrdata_d       = wrdata_q;
`ifdef I2C_VERIFY_EN
        rd_sent_d      = rd_sent_q;
`endif
        w_dly_load     = 1'b0;
        w_dly_dec      = 1'b0;
        w_attempt_fail = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d      = 1'b1;
                    err_d       = 1'b0;
                    lut_index_d = '0;
                    retry_d     = '0;
                    w_dly_load  = 1'b1;
                    state_d     = ST_PWR_DLY;
                end
            end
            ST_PWR_DLY: begin
                if (w_dly_zero) begin
                    state_d = ST_FETCH;
                end else begin
                    w_dly_dec = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                addr_d   = entry_addr(lut_data);
                wrdata_d = entry_data(lut_data);
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                if (RW_Done) begin
                    if (ack) begin
                        w_attempt_fail = 1'b1;
                    end else begin
`ifdef I2C_VERIFY_EN
                        rd_sent_d = 1'b0;
                        state_d   = ST_VERIFY;
`else
                        state_d   = ST_NEXT;
`endif
                    end
                end
            end
`ifdef I2C_VERIFY_EN
            ST_VERIFY: begin
                if (!rd_sent_q) begin
                    rd_sent_d = 1'b1;
                end else if (RW_Done) begin
                    if (ack || (rddata != wrdata_q)) begin
                        w_attempt_fail = 1'b1;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
`endif
            ST_NEXT: begin
                retry_d = '0;
                if (lut_index_q == LAST_IDX) begin
                    state_d = ST_FIN;
                end else begin
                    lut_index_d = lut_index_q + 10'd1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A failed write or a failed read-back rewrites the same entry, until
        // the retry budget is used up.
        if (w_attempt_fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + {{(RETRY_W-1){1'b0}}, 1'b1};
                state_d = ST_ISSUE;
            end else begin
                err_d       = 1'b1;
                err_index_d = lut_index_q;
                state_d     = ST_FIN;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= '0;
            lut_index_q <= '0;
            retry_q     <= '0;
            addr_q      <= '0;
            wrdata_q    <= '0;
`ifdef I2C_VERIFY_EN
            rd_sent_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
            lut_index_q <= lut_index_d;
            retry_q     <= retry_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
`ifdef I2C_VERIFY_EN
            rd_sent_q   <= rd_sent_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = (state_q == ST_FIN);
    assign err         = err_q;
    assign err_index   = err_index_q;
    assign lut_index   = lut_index_q;
    assign wrreg_req   = (state_q == ST_ISSUE);
    assign addr        = addr_q;
    assign wrdata      = wrdata_q;
    assign addr_mode   = ADDR_MODE;
    assign device_id   = DEVICE_ID;
    assign dly_cnt_max = GAP_CYC;

`ifdef I2C_VERIFY_EN
    assign rdreg_req = (state_q == ST_VERIFY) && !rd_sent_q;
`else
    assign rdreg_req = 1'b0;
    logic w_unused_rddata;
    assign w_unused_rddata = ^rddata;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2c_init_seq
//  Description : Self-checking bench for i2c_init_seq (LUT_SIZE=4,
//                PWR_DLY_CYC=10, MAX_RETRY=3). A controller model answers
//                requests, and a scoreboard queue holds the expected writes.
//                With I2C_VERIFY_EN defined, the read-back abort case is
//                also run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_init_seq;

    localparam int LUT_SIZE = 4;
    localparam int LAT      = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        start = 1'b0;
    logic        RW_Done = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  rddata = 8'h00;
    logic [23:0] lut_data = 24'h0;
    logic        busy, done, err, wrreg_req, rdreg_req, addr_mode;
    logic [9:0]  err_index, lut_index;
    logic [15:0] addr;
    logic [7:0]  wrdata, device_id;
    logic [31:0] dly_cnt_max;

    logic [23:0] rom [0:3] = '{24'h30_08_82, 24'h31_03_03, 24'h30_17_FF, 24'h47_40_21};

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;

    int n_checks = 0;
    int n_pass   = 0;
    int nack_idx = -1;
    int nack_left = 0;
    int vbad_idx = -1;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int last_wr_idx = -1;
    int busy_low = 0;
    bit got_done;

    i2c_init_seq #(
        .LUT_SIZE    (LUT_SIZE),
        .DEVICE_ID   (8'h78),
        .ADDR_MODE   (1'b1),
        .PWR_DLY_CYC (32'd10),
        .MAX_RETRY   (3),
        .GAP_CYC     (32'd500)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_index   (err_index),
        .lut_index   (lut_index),
        .lut_data    (lut_data),
        .wrreg_req   (wrreg_req),
        .rdreg_req   (rdreg_req),
        .addr        (addr),
        .addr_mode   (addr_mode),
        .wrdata      (wrdata),
        .device_id   (device_id),
        .dly_cnt_max (dly_cnt_max),
        .RW_Done     (RW_Done),
        .ack         (ack),
        .rddata      (rddata)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM, with one cycle of read latency
    always @(posedge Clk) lut_data <= rom[lut_index[1:0]];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_entry(input int idx, input int times);
        exp_t e;
        for (int k = 0; k < times; k++) begin
            e.idx = idx;
            e.a   = rom[idx][23:8];
            e.d   = rom[idx][7:0];
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
    endtask

    // Returns at the negedge on which done is seen, or at budget expiry.
    task automatic wait_done(input int budget);
        got_done = 1'b0;
        busy_low = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge Clk);
            if (busy !== 1'b1) busy_low++;
            if (done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
        end
        check_val("seq_done_seen", {31'd0, got_done}, 32'd1);
        check_val("busy_held", busy_low, 0);
    endtask

    // Checks on the cycle after done
    task automatic post_checks(input string t, input int exp_wr, input bit exp_err,
                               input int exp_eidx);
        @(negedge Clk);
        check_val({t, "_busy_low"}, {31'd0, busy}, 32'd0);
        check_val({t, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_val({t, "_done_cnt"}, done_cnt, 1);
        check_val({t, "_wr_cnt"}, wr_cnt, exp_wr);
        check_val({t, "_sb_empty"}, sb.size(), 0);
        check_val({t, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (exp_err) check_val({t, "_err_index"}, {22'd0, err_index}, exp_eidx);
    endtask

    // Controller model: answers each request LAT cycles after it is seen
    initial begin
        forever begin
            @(posedge Clk); #1;
            RW_Done = 1'b0;
            ack     = 1'b0;
            if (wrreg_req === 1'b1) begin
                wr_cnt++;
                check_val("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
                if (sb.size() > 0) begin
                    e_cur = sb.pop_front();
                    check_val("wr_addr", {16'd0, addr}, {16'd0, e_cur.a});
                    check_val("wr_data", {24'd0, wrdata}, {24'd0, e_cur.d});
                end
                last_wr_idx = e_cur.idx;
                repeat (LAT) @(posedge Clk);
                #1;
                RW_Done = 1'b1;
                ack     = (e_cur.idx == nack_idx) && (nack_left > 0);
                if (ack) nack_left--;
            end else if (rdreg_req === 1'b1) begin
                rd_cnt++;
                check_val("rd_addr", {16'd0, addr}, {16'd0, e_cur.a});
                repeat (LAT) @(posedge Clk);
                #1;
                RW_Done = 1'b1;
                ack     = 1'b0;
                rddata  = (e_cur.idx == vbad_idx) ? (e_cur.d ^ 8'h01) : e_cur.d;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge Clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_wrreg", {31'd0, wrreg_req}, 32'd0);
        check_val("rst_rdreg", {31'd0, rdreg_req}, 32'd0);
        check_val("rst_lut_index", {22'd0, lut_index}, 32'd0);
        check_val("rst_addr", {16'd0, addr}, 32'd0);
        check_val("rst_wrdata", {24'd0, wrdata}, 32'd0);
        check_val("rst_err_index", {22'd0, err_index}, 32'd0);
        check_val("addr_mode", {31'd0, addr_mode}, 32'd1);
        check_val("device_id", {24'd0, device_id}, 32'h78);
        check_val("dly_cnt_max", dly_cnt_max, 32'd500);
        Rst = 1'b0;

        // Test 1: all entries ACKed
        for (int i = 0; i < LUT_SIZE; i++) push_entry(i, 1);
        done_cnt = 0; wr_cnt = 0;
        pulse_start();
        check_val("t1_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(500);
        post_checks("t1", 4, 1'b0, 0);

        // Test 2: entry 2 NACKs twice, then ACKs
        nack_idx = 2; nack_left = 2;
        push_entry(0, 1); push_entry(1, 1); push_entry(2, 3); push_entry(3, 1);
        done_cnt = 0; wr_cnt = 0;
        pulse_start();
        wait_done(500);
        post_checks("t2", 6, 1'b0, 0);

        // Test 3: entry 1 always NACKs, so the sequence aborts
        nack_idx = 1; nack_left = 1000;
        push_entry(0, 1); push_entry(1, 4);
        done_cnt = 0; wr_cnt = 0;
        pulse_start();
        wait_done(500);
        post_checks("t3", 5, 1'b1, 1);

        // Test 4: restart right after done, clearing err. A start pulse
        // while busy is ignored.
        nack_idx = -1; nack_left = 0;
        for (int i = 0; i < LUT_SIZE; i++) push_entry(i, 1);
        done_cnt = 0; wr_cnt = 0;
        check_val("t4_err_sticky", {31'd0, err}, 32'd1);
        start = 1'b1;
        @(negedge Clk); start = 1'b0;
        check_val("t4_err_cleared", {31'd0, err}, 32'd0);
        check_val("t4_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge Clk);
        start = 1'b1;
        @(negedge Clk); start = 1'b0;
        wait_done(500);
        post_checks("t4", 4, 1'b0, 0);

        // Test 5: reset during WAIT_WR of entry 2
        push_entry(0, 1); push_entry(1, 1); push_entry(2, 1);
        last_wr_idx = -1;
        pulse_start();
        for (int c = 0; c < 300 && last_wr_idx != 2; c++) @(negedge Clk);
        check_val("t5_reached_entry2", last_wr_idx, 2);
        Rst = 1'b1;
        @(negedge Clk);
        check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
        check_val("t5_rst_done", {31'd0, done}, 32'd0);
        check_val("t5_rst_err", {31'd0, err}, 32'd0);
        check_val("t5_rst_wrreg", {31'd0, wrreg_req}, 32'd0);
        check_val("t5_rst_lut_index", {22'd0, lut_index}, 32'd0);
        check_val("t5_rst_addr", {16'd0, addr}, 32'd0);
        check_val("t5_rst_wrdata", {24'd0, wrdata}, 32'd0);
        Rst = 1'b0;
        check_val("t5_sb_drained", sb.size(), 0);
        repeat (LAT + 3) @(negedge Clk);
        for (int i = 0; i < LUT_SIZE; i++) push_entry(i, 1);
        done_cnt = 0; wr_cnt = 0;
        pulse_start();
        wait_done(500);
        post_checks("t5", 4, 1'b0, 0);

`ifdef I2C_VERIFY_EN
        // Test 6: read-back of entry 0 always mismatches
        vbad_idx = 0;
        push_entry(0, 4);
        done_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        pulse_start();
        wait_done(500);
        post_checks("t6", 4, 1'b1, 0);
        check_val("t6_rd_cnt", rd_cnt, 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
